// File: rtl/seq_multiplier_n_if.sv
// Handshake bundle for seq_multiplier_n: operand channel, product channel and busy flag.
// The signed_op signal exists only when SIGNED_MODE_EN is defined.
interface seq_multiplier_n_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
`ifdef SIGNED_MODE_EN
  logic                 signed_op;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   P;
  logic                 busy;

  modport master (
`ifdef SIGNED_MODE_EN
    output signed_op,
`endif
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, P, busy
  );

  modport slave (
`ifdef SIGNED_MODE_EN
    input  signed_op,
`endif
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, P, busy
  );
endinterface

// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier, one multiplier bit retired per clock, valid/ready on both sides.
// Optional macro SIGNED_MODE_EN adds two's-complement operation selected per transaction by signed_op.
module seq_multiplier_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  seq_multiplier_n_if.slave  bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_p;
  logic             r_neg;

  logic             w_accept;
  logic             w_last;
  logic             w_out_hs;
  logic [PW-1:0]    w_a_shift;
  logic [PW-1:0]    w_acc_next;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_neg_in;

  assign w_accept   = bus.in_valid && (r_state == S_IDLE);
  assign w_out_hs   = bus.out_ready && (r_state == S_DONE);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_a_shift  = {{WIDTH{1'b0}}, r_a} << r_cnt;
  assign w_acc_next = r_b[r_cnt] ? (r_acc + w_a_shift) : r_acc;

  // Signed operands are reduced to magnitudes at accept; the sign is reapplied on the DONE load.
`ifdef SIGNED_MODE_EN
  logic w_a_neg;
  logic w_b_neg;
  assign w_a_neg  = bus.signed_op && bus.A[WIDTH-1];
  assign w_b_neg  = bus.signed_op && bus.B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -bus.A : bus.A;
  assign w_b_mag  = w_b_neg ? -bus.B : bus.B;
  assign w_neg_in = w_a_neg ^ w_b_neg;
`else
  assign w_a_mag  = bus.A;
  assign w_b_mag  = bus.B;
  assign w_neg_in = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUSY;
      S_BUSY:  if (w_last)   w_next = S_DONE;
      S_DONE:  if (w_out_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == S_IDLE) && !rst;
    bus.busy      = (r_state == S_BUSY);
    bus.out_valid = (r_state == S_DONE);
    bus.P         = r_p;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_acc <= '0;
      r_p   <= '0;
      r_neg <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= w_a_mag;
            r_b   <= w_b_mag;
            r_neg <= w_neg_in;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_p <= r_neg ? -w_acc_next : w_acc_next;
        end
        default: ;
      endcase
    end
  end
endmodule
